// File: rtl/gray_demux_pkg.sv
// Shared Gray/binary conversion helpers so encoder and decoder agree on one definition.
package gray_demux_pkg;

  localparam int unsigned WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;

  // Prefix-XOR decode; bits of g at or above width must be zero.
  function automatic word_t gray2bin(input word_t g, input int unsigned width);
    word_t b;
    b = g;
    for (int s = 1; s < int'(WORD_W); s++) begin
      if (s < int'(width)) b = b ^ (g >> s);
    end
    return b;
  endfunction

  function automatic word_t bin2gray(input word_t i);
    return i ^ (i >> 1);
  endfunction

endpackage

// File: rtl/gray_demux_mux.sv
// Keyed lookup: returns the data field of the entry whose key field equals sel, else def.
module Mux #(
  parameter int NR_ENTRY = 2,
  parameter int KEY_W    = 1,
  parameter int DATA_W   = 1
) (
  input  logic [KEY_W-1:0]                 sel,
  input  logic [NR_ENTRY*(KEY_W+DATA_W)-1:0] lut,
  input  logic [DATA_W-1:0]                def,
  output logic [DATA_W-1:0]                out
);

  localparam int ENT_W = KEY_W + DATA_W;

  always_comb begin
    out = def;
    for (int i = 0; i < NR_ENTRY; i++) begin
      if (lut[i*ENT_W + DATA_W +: KEY_W] == sel) out = lut[i*ENT_W +: DATA_W];
    end
  end

endmodule

// File: rtl/gray_demux.sv
// Two-stage Gray-index decoder and key-table lookup on a valid/ready stream.
// Latency 2 cycles, full throughput; in_ready falls only when both stages hold data and out_ready is low.
module gray_demux
  import gray_demux_pkg::*;
#(
  parameter int NR_KEY     = 2,
  parameter int KEY_WIDTH  = 1,
  parameter int DATA_WIDTH = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_gray,
  input  logic [NR_KEY*KEY_WIDTH-1:0]  keys,
  input  logic [KEY_WIDTH-1:0]         def,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [KEY_WIDTH-1:0]         out_key,
  output logic [DATA_WIDTH-1:0]        out_index,
  output logic                         out_miss
);

  localparam int ENT_W = DATA_WIDTH + KEY_WIDTH;

  logic                    s1_v_q, s1_v_d;
  logic [DATA_WIDTH-1:0]   s1_idx_q, s1_idx_d;
  logic                    s2_v_q, s2_v_d;
  logic [KEY_WIDTH-1:0]    key_q, key_d;
  logic [DATA_WIDTH-1:0]   idx_q, idx_d;
  logic                    miss_q, miss_d;

  logic                    adv2;
  logic                    accept;
  logic [NR_KEY*ENT_W-1:0] lut;
  logic [KEY_WIDTH-1:0]    lut_key;

  // Each entry carries its own index as the match key, so out-of-range indices fall to def.
  for (genvar i = 0; i < NR_KEY; i++) begin : g_lut
    assign lut[i*ENT_W +: ENT_W] = {DATA_WIDTH'(i), keys[i*KEY_WIDTH +: KEY_WIDTH]};
  end

  Mux #(
    .NR_ENTRY (NR_KEY),
    .KEY_W    (DATA_WIDTH),
    .DATA_W   (KEY_WIDTH)
  ) u_lookup (
    .sel (s1_idx_q),
    .lut (lut),
    .def (def),
    .out (lut_key)
  );

  assign adv2      = s1_v_q && (!s2_v_q || out_ready);
  assign in_ready  = !s1_v_q || adv2;
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_v_q;
  assign out_key   = key_q;
  assign out_index = idx_q;
  assign out_miss  = miss_q;

  always_comb begin
    s1_idx_d = s1_idx_q;
    key_d    = key_q;
    idx_d    = idx_q;
    miss_d   = miss_q;
    if (accept) s1_idx_d = DATA_WIDTH'(gray2bin(word_t'(in_gray), DATA_WIDTH));
    // keys/def are sampled only here, so a stalled output cannot change under the consumer.
    if (adv2) begin
      idx_d  = s1_idx_q;
      miss_d = (word_t'(s1_idx_q) >= word_t'(NR_KEY));
      key_d  = lut_key;
    end
    s1_v_d = accept || (s1_v_q && !adv2);
    s2_v_d = adv2 || (s2_v_q && !out_ready);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v_q   <= 1'b0;
      s1_idx_q <= '0;
      s2_v_q   <= 1'b0;
      key_q    <= '0;
      idx_q    <= '0;
      miss_q   <= 1'b0;
    end else begin
      s1_v_q   <= s1_v_d;
      s1_idx_q <= s1_idx_d;
      s2_v_q   <= s2_v_d;
      key_q    <= key_d;
      idx_q    <= idx_d;
      miss_q   <= miss_d;
    end
  end

endmodule

// File: tb/tb_gray_demux.sv
// Bench for gray_demux: a full table (NR_KEY=4) and a short table (NR_KEY=3) driven in lockstep.
module tb_gray_demux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [1:0]  in_gray = 2'b00;
  logic [7:0]  ktab [4];
  logic [7:0]  def = 8'hEE;
  logic [31:0] keys_a;
  logic [23:0] keys_b;

  logic        ir_a, ov_a, miss_a, ir_b, ov_b, miss_b;
  logic [7:0]  key_a, key_b;
  logic [1:0]  idx_a, idx_b;

  assign keys_a = {ktab[3], ktab[2], ktab[1], ktab[0]};
  assign keys_b = {ktab[2], ktab[1], ktab[0]};

  always #5 clk = ~clk;

  gray_demux #(.NR_KEY(4), .KEY_WIDTH(8), .DATA_WIDTH(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_a), .in_gray(in_gray),
    .keys(keys_a), .def(def), .out_valid(ov_a), .out_ready(out_ready),
    .out_key(key_a), .out_index(idx_a), .out_miss(miss_a));

  gray_demux #(.NR_KEY(3), .KEY_WIDTH(8), .DATA_WIDTH(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_b), .in_gray(in_gray),
    .keys(keys_b), .def(def), .out_valid(ov_b), .out_ready(out_ready),
    .out_key(key_b), .out_index(idx_b), .out_miss(miss_b));

  typedef struct {
    int         stamp;
    int         idx;
    logic [7:0] ka;
    logic [7:0] kb;
    logic       mb;
  } exp_t;

  typedef struct {
    int         cyc;
    logic [7:0] key;
    int         idx;
    logic       miss;
  } obs_t;

  exp_t q[$];
  obs_t log_a[$];
  obs_t log_b[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int last_acc_cyc = 0;
  bit rst_seen = 1'b0;
  bit hold_a = 1'b0, hold_b = 1'b0;
  logic [10:0] held_a, held_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Inverse Gray by search: the index whose Gray code equals g.
  function automatic int ungray(input int g);
    for (int b = 0; b < 4; b++) if ((b ^ (b >> 1)) == g) return b;
    return -1;
  endfunction

  // Reference model: an ordered list of in-flight items; one compare process per cycle.
  always @(negedge clk) begin
    exp_t e;
    obs_t o;
    bit   exp_vld;
    bit   exp_rdy;
    cyc++;
    if (!rst_n) begin
      q.delete();
      rst_seen = 1'b1;
      hold_a = 1'b0;
      hold_b = 1'b0;
    end else begin
      if (rst_seen) begin
        check("rst_outputs_a", {ov_a, key_a, idx_a, miss_a}, 0);
        check("rst_outputs_b", {ov_b, key_b, idx_b, miss_b}, 0);
        check("rst_in_ready", {ir_a, ir_b}, 2'b11);
        rst_seen = 1'b0;
      end
      exp_rdy = !(q.size() == 2 && !out_ready);
      exp_vld = 1'b0;
      if (q.size() > 0) exp_vld = (q[0].stamp + 2 <= cyc);
      check("in_ready_a", ir_a, exp_rdy);
      check("in_ready_b", ir_b, exp_rdy);
      check("out_valid_a", ov_a, exp_vld);
      check("out_valid_b", ov_b, exp_vld);
      if (exp_vld && ov_a) begin
        check("out_a", {key_a, idx_a, miss_a}, {q[0].ka, 2'(q[0].idx), 1'b0});
        check("out_b", {key_b, idx_b, miss_b}, {q[0].kb, 2'(q[0].idx), q[0].mb});
      end
      if (hold_a) check("stall_stable_a", {key_a, idx_a, miss_a}, held_a);
      if (hold_b) check("stall_stable_b", {key_b, idx_b, miss_b}, held_b);
      hold_a = ov_a && !out_ready;
      hold_b = ov_b && !out_ready;
      held_a = {key_a, idx_a, miss_a};
      held_b = {key_b, idx_b, miss_b};
      if (ov_a && out_ready) begin
        o.cyc = cyc; o.key = key_a; o.idx = int'(idx_a); o.miss = miss_a;
        log_a.push_back(o);
      end
      if (ov_b && out_ready) begin
        o.cyc = cyc; o.key = key_b; o.idx = int'(idx_b); o.miss = miss_b;
        log_b.push_back(o);
      end
      if (exp_vld && out_ready) void'(q.pop_front());
      if (in_valid && ir_a) begin
        e.stamp = cyc;
        e.idx   = ungray(int'(in_gray));
        e.ka    = ktab[e.idx];
        e.mb    = (e.idx >= 3);
        e.kb    = e.mb ? def : ktab[e.idx];
        q.push_back(e);
        acc_cnt++;
        last_acc_cyc = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send(input logic [1:0] g);
    int n0;
    n0 = acc_cnt;
    in_valid = 1'b1;
    in_gray = g;
    for (int i = 0; i < 50 && acc_cnt == n0; i++) step();
    check("send_accept", 32'(acc_cnt - n0), 1);
    in_valid = 1'b0;
  endtask

  initial begin
    int s0, base, c;
    ktab[0] = 8'h11; ktab[1] = 8'h22; ktab[2] = 8'h33; ktab[3] = 8'h44;
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Decode sweep, back-to-back
    log_a.delete();
    out_ready = 1'b1;
    send(2'b00);
    s0 = last_acc_cyc;
    send(2'b01);
    send(2'b11);
    send(2'b10);
    idle(4);
    check("sweep_count", log_a.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < log_a.size()) begin
        check("sweep_key", log_a[i].key, 32'(8'h11 * (i + 1)));
        check("sweep_idx", log_a[i].idx, i);
        check("sweep_miss", log_a[i].miss, 0);
      end
    end
    if (log_a.size() == 4) begin
      check("sweep_latency", log_a[0].cyc - s0, 2);
      check("sweep_rate", log_a[3].cyc - log_a[0].cyc, 3);
    end

    // Miss on the 3-entry table
    log_a.delete();
    log_b.delete();
    send(2'b10);
    idle(3);
    check("miss_count_b", log_b.size(), 1);
    if (log_b.size() > 0) begin
      check("miss_key", log_b[0].key, 8'hEE);
      check("miss_idx", log_b[0].idx, 3);
      check("miss_flag", log_b[0].miss, 1);
    end

    // Backpressure
    log_a.delete();
    out_ready = 1'b0;
    send(2'b01);
    send(2'b11);
    in_valid = 1'b1;
    in_gray = 2'b10;
    repeat (3) begin
      step();
      check("bp_in_ready", ir_a, 0);
      check("bp_hold_key", key_a, 8'h22);
    end
    s0 = acc_cnt;
    out_ready = 1'b1;
    #1;
    check("bp_recover_ready", ir_a, 1);
    step();
    check("bp_third_accept", 32'(acc_cnt - s0), 1);
    in_valid = 1'b0;
    idle(4);
    check("bp_count", log_a.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < log_a.size()) check("bp_order", log_a[i].key, 32'(8'h22 + 8'h11 * i));
    end

    // Key-table change while stalled
    log_a.delete();
    out_ready = 1'b0;
    send(2'b11);
    step();
    ktab[2] = 8'h99;
    repeat (3) begin
      step();
      check("kc_hold_key", key_a, 8'h33);
    end
    out_ready = 1'b1;
    step();
    send(2'b11);
    idle(4);
    check("kc_count", log_a.size(), 2);
    if (log_a.size() == 2) begin
      check("kc_old_key", log_a[0].key, 8'h33);
      check("kc_new_key", log_a[1].key, 8'h99);
    end
    ktab[2] = 8'h33;

    // Reset with both stages full
    out_ready = 1'b0;
    send(2'b00);
    send(2'b01);
    check("rstmid_full", ir_a, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rstmid_valid", ov_a, 0);
    check("rstmid_ready", ir_a, 1);
    log_a.delete();
    out_ready = 1'b1;
    idle(5);
    check("rstmid_no_stale", log_a.size(), 0);

    // Random traffic
    base = acc_cnt;
    c = 0;
    while ((acc_cnt - base) < 10000 && c < 40000) begin
      in_valid  = ($urandom_range(3) != 0);
      in_gray   = 2'($urandom_range(3));
      out_ready = ($urandom_range(3) != 0);
      step();
      c++;
    end
    in_valid = 1'b0;
    check("rand_accepts", 32'(acc_cnt - base), 10000);
    out_ready = 1'b1;
    idle(5);
    check("rand_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
